// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory stage of the 8-bit pipelined core.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEST_W = 2;
    localparam int CNT_W      = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory: 2**ADDR_W x DATA_W words, asynchronous clear and read, synchronous write.
module data_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array sits in the reset branch because the core relies on a
    // cleared memory after reset; without that need it would be left out so
    // the array can map onto a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: stalls upstream for MEM_LATENCY extra cycles per load/store,
// then registers the instruction into the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = mem_stage_pkg::DEF_DATA_W,
    parameter int ADDR_W      = mem_stage_pkg::DEF_ADDR_W,
    parameter int DEST_W      = mem_stage_pkg::DEF_DEST_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] Val_Ra_in,
    input  logic [DATA_W-1:0] ALU_Res_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              freeze,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] Mem_Data,
    output logic [DEST_W-1:0] Dest
);

    localparam bit              HAS_WAIT = (MEM_LATENCY != 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = HAS_WAIT ? CNT_W'(MEM_LATENCY - 1) : '0;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              req;
    logic              complete;
    logic              mem_we;
    logic [DATA_W-1:0] rd_data;

    assign req = MEM_R_EN_in | MEM_W_EN_in;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req && HAS_WAIT) next_state = BUSY;
            BUSY: if (cnt == '0)       next_state = IDLE;
            default:                   next_state = IDLE;
        endcase
    end

    // Freeze is gated by rst so an aborted access releases upstream at once.
    always_comb begin
        freeze   = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                freeze   = req && HAS_WAIT;
                complete = req && !HAS_WAIT;
            end
            BUSY: begin
                freeze   = (cnt != '0);
                complete = (cnt == '0);
            end
            default: ;
        endcase
        if (rst) begin
            freeze   = 1'b0;
            complete = 1'b0;
        end
        mem_we = complete && MEM_W_EN_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE && req && HAS_WAIT) begin
            cnt <= CNT_LOAD;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .addr  (ALU_Res_in[ADDR_W-1:0]),
        .wdata (Val_Ra_in),
        .rdata (rd_data)
    );

    // Frozen cycles inject a bubble so the held instruction is written back once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            ALU_Res  <= '0;
            Mem_Data <= '0;
            Dest     <= '0;
        end else if (freeze) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
        end else begin
            WB_EN    <= WB_EN_in;
            MEM_R_EN <= MEM_R_EN_in;
            ALU_Res  <= ALU_Res_in;
            Dest     <= Dest_in;
            if (complete && MEM_R_EN_in) begin
                Mem_Data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model checked every cycle, plus literal expectations.
module tb_mem_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_in, r_in, w_in;
    logic [7:0] val_in, alu_in;
    logic [1:0] dest_in;

    logic       f2, wb2, mr2;
    logic [7:0] alu2, md2;
    logic [1:0] dest2;
    logic       f0, wb0, mr0;
    logic [7:0] alu0, md0;
    logic [1:0] dest0;

    mem_stage #(.MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .WB_EN_in(wb_in), .MEM_R_EN_in(r_in), .MEM_W_EN_in(w_in),
        .Val_Ra_in(val_in), .ALU_Res_in(alu_in), .Dest_in(dest_in), .freeze(f2),
        .WB_EN(wb2), .MEM_R_EN(mr2), .ALU_Res(alu2), .Mem_Data(md2), .Dest(dest2)
    );

    mem_stage #(.MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .WB_EN_in(wb_in), .MEM_R_EN_in(r_in), .MEM_W_EN_in(w_in),
        .Val_Ra_in(val_in), .ALU_Res_in(alu_in), .Dest_in(dest_in), .freeze(f0),
        .WB_EN(wb0), .MEM_R_EN(mr0), .ALU_Res(alu0), .Mem_Data(md0), .Dest(dest0)
    );

    always #5 clk = ~clk;

    // Output mux for whichever build is currently under test.
    bit         sel0 = 1'b0;
    logic       fz, wb, mr;
    logic [7:0] alu, md;
    logic [1:0] dest;
    assign fz   = sel0 ? f0    : f2;
    assign wb   = sel0 ? wb0   : wb2;
    assign mr   = sel0 ? mr0   : mr2;
    assign alu  = sel0 ? alu0  : alu2;
    assign md   = sel0 ? md0   : md2;
    assign dest = sel0 ? dest0 : dest2;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model state: expected MEM/WB contents, expected freeze and a plain memory image.
    logic [7:0] m [256];
    logic       e_fz, e_wb, e_mr;
    logic [7:0] e_alu, e_md;
    logic [1:0] e_dest;
    bit         chk_en = 1'b0;
    int         fz_cnt = 0;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m[i] = 8'h00;
        e_fz = 0; e_wb = 0; e_mr = 0; e_alu = 0; e_md = 0; e_dest = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (fz === 1'b1) fz_cnt++;
            check("freeze",   {7'd0, fz},  {7'd0, e_fz});
            check("WB_EN",    {7'd0, wb},  {7'd0, e_wb});
            check("MEM_R_EN", {7'd0, mr},  {7'd0, e_mr});
            check("ALU_Res",  alu,         e_alu);
            check("Mem_Data", md,          e_md);
            check("Dest",     {6'd0, dest}, {6'd0, e_dest});
        end
    end

    // One instruction: held for its full occupancy, model updated at each edge.
    task automatic op(input bit owb, input bit rd, input bit wr,
                      input logic [7:0] val, input logic [7:0] a, input logic [1:0] d);
        int lat;
        lat = (rd || wr) ? (sel0 ? 0 : 2) : 0;
        wb_in = owb; r_in = rd; w_in = wr; val_in = val; alu_in = a; dest_in = d;
        for (int k = 0; k <= lat; k++) begin
            e_fz = (k < lat);
            @(posedge clk);
            if (k < lat) begin
                e_wb = 0; e_mr = 0;
            end else begin
                if (rd) e_md = m[a];
                if (wr) m[a] = val;
                e_wb = owb; e_mr = rd; e_alu = a; e_dest = d;
            end
            #1;
        end
    endtask

    task automatic nop();
        op(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        wb_in = 0; r_in = 0; w_in = 0; val_in = 0; alu_in = 0; dest_in = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        do_reset();

        check("rst_alu",    alu, 8'h00);
        check("rst_md",     md,  8'h00);
        check("rst_freeze", {7'd0, fz}, 8'h00);

        // Non-memory pass-through.
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h3C, 2'd2);
        check("nop_alu",  alu, 8'h3C);
        check("nop_dest", {6'd0, dest}, 8'h02);
        check("nop_wb",   {7'd0, wb}, 8'h01);
        nop();

        // Store 0x10 <- A5, freeze must be high exactly two cycles.
        fz_cnt = 0;
        op(1'b0, 1'b0, 1'b1, 8'hA5, 8'h10, 2'd0);
        check("st_fz_cycles", 8'(fz_cnt), 8'h02);

        // Load it back.
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 2'd3);
        check("ld_md",   md, 8'hA5);
        check("ld_mr",   {7'd0, mr}, 8'h01);
        check("ld_dest", {6'd0, dest}, 8'h03);
        nop();
        check("ld_wb_drop", {7'd0, wb}, 8'h00);

        // Reset while the store to 0x20 is in flight.
        wb_in = 0; r_in = 0; w_in = 1; val_in = 8'h77; alu_in = 8'h20; dest_in = 2'd1;
        e_fz = 1'b1;
        @(posedge clk);
        e_wb = 0; e_mr = 0;
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("abort_freeze", {7'd0, fz}, 8'h00);
        check("abort_wb",     {7'd0, wb}, 8'h00);
        check("abort_alu",    alu, 8'h00);
        check("abort_dest",   {6'd0, dest}, 8'h00);
        #1 rst = 1'b0;
        nop();
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 2'd1);
        check("abort_ld", md, 8'h00);

        // Both enables: read-before-write.
        op(1'b0, 1'b0, 1'b1, 8'h11, 8'h05, 2'd0);
        op(1'b1, 1'b1, 1'b1, 8'h22, 8'h05, 2'd2);
        check("rbw_md", md, 8'h11);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h05, 2'd2);
        check("rbw_mem", md, 8'h22);

        // Address wrap and a few mixed ops.
        op(1'b0, 1'b0, 1'b1, 8'h5A, 8'hFF, 2'd0);
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 2'd1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 2'd0);
        check("wrap_ld", md, 8'h5A);
        nop();

        // Zero-latency build: one instruction per cycle, freeze never high.
        sel0 = 1'b1;
        do_reset();
        fz_cnt = 0;
        op(1'b0, 1'b0, 1'b1, 8'h33, 8'h40, 2'd0);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 2'd1);
        check("l0_ld", md, 8'h33);
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h9E, 2'd3);
        check("l0_alu", alu, 8'h9E);
        check("l0_md_hold", md, 8'h33);
        op(1'b0, 1'b0, 1'b1, 8'h44, 8'h41, 2'd0);
        op(1'b1, 1'b1, 1'b1, 8'h55, 8'h41, 2'd2);
        check("l0_rbw", md, 8'h44);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h41, 2'd2);
        check("l0_rbw_mem", md, 8'h55);
        nop();
        check("l0_fz_cycles", 8'(fz_cnt), 8'h00);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
